stream_demux: RTL and testbench

- 1-to-n stream demultiplexer: routes a valid/ready input stream to one of n_cell output channels.
- Destination comes from an explicit select or an internal round-robin pointer.
- Each channel has a one-entry output register, giving 1-cycle latency and per-channel backpressure.
- Sits downstream of the neural-net processing pipeline and fans results out to per-unit consumers. It is the distributing counterpart of the n-way Mux.

---
 rtl/stream_demux_if.sv | 32 +++
 rtl/stream_demux.sv | 100 ++++++++++
 tb/tb_stream_demux.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_if.sv
// Stream demux bundle: one valid/ready input stream, n_cell output channels,
// plus the round-robin pointer and accepted-beat counter status outputs.
interface stream_demux_if #(
  parameter int switch_bits = 1,
  parameter int data_width  = 8,
  parameter int count_width = 16
);
  localparam int n_cell = 1 << switch_bits;

  logic                         in_valid;
  logic                         in_ready;
  logic [switch_bits-1:0]       in_sel;
  logic [data_width-1:0]        in_data;
  logic                         rr_en;
  logic [n_cell-1:0]            out_valid;
  logic [n_cell-1:0]            out_ready;
  logic [n_cell*data_width-1:0] out_data;
  logic [switch_bits-1:0]       rr_ptr;
  logic [count_width-1:0]       beat_count;

  // Producer / consumer side (drives the input stream and the channel readies).
  modport master (
    output in_valid, in_sel, in_data, rr_en, out_ready,
    input  in_ready, out_valid, out_data, rr_ptr, beat_count
  );

  // Demux side.
  modport slave (
    input  in_valid, in_sel, in_data, rr_en, out_ready,
    output in_ready, out_valid, out_data, rr_ptr, beat_count
  );
endinterface

// File: rtl/stream_demux.sv
// 1-to-n stream demultiplexer. Each channel owns a one-entry output register,
// so a beat appears on its channel one cycle after acceptance and each channel
// back-pressures independently. Destination is in_sel or a strict round-robin
// pointer that never skips a busy channel.
module stream_demux #(
  parameter int switch_bits = 1,
  parameter int data_width  = 8,
  parameter int count_width = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  stream_demux_if.slave  bus
);
  localparam int n_cell = 1 << switch_bits;

  logic [switch_bits-1:0]       dest;
  logic                         in_ready;
  logic                         accept;
  logic [switch_bits-1:0]       rr_ptr_reg;
  logic [switch_bits-1:0]       rr_ptr_next;
  logic [count_width-1:0]       beat_count_reg;
  logic [count_width-1:0]       beat_count_next;
  logic [n_cell-1:0]            out_valid_flat;
  logic [n_cell*data_width-1:0] out_data_flat;

  // Destination select and ready: ready looks only at the destination
  // channel's slot (empty, or draining this cycle), never at in_valid.
  always_comb begin
    dest     = bus.rr_en ? rr_ptr_reg : bus.in_sel;
    in_ready = !out_valid_flat[dest] || bus.out_ready[dest];
    accept   = bus.in_valid && in_ready;
  end

  for (genvar gi = 0; gi < n_cell; gi++) begin : g_chan
    logic                  wr;
    logic                  valid_reg;
    logic                  valid_next;
    logic [data_width-1:0] data_reg;
    logic [data_width-1:0] data_next;

    assign wr = accept && (dest == switch_bits'(gi));

    // Slot update: a write wins over a drain so a draining slot refills in
    // the same cycle; data is only touched on a write so it holds otherwise.
    always_comb begin
      valid_next = valid_reg;
      data_next  = data_reg;
      if (wr) begin
        valid_next = 1'b1;
        data_next  = bus.in_data;
      end else if (valid_reg && bus.out_ready[gi]) begin
        valid_next = 1'b0;
      end
    end

    // Channel slot register; reset discards any buffered beat.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
      end else begin
        valid_reg <= valid_next;
        data_reg  <= data_next;
      end
    end

    assign out_valid_flat[gi]                            = valid_reg;
    assign out_data_flat[gi*data_width +: data_width]    = data_reg;
  end

  // Pointer advances only on an accepted rr beat (natural wrap at n_cell);
  // the beat counter advances on every accept and wraps modulo its width.
  always_comb begin
    rr_ptr_next     = rr_ptr_reg;
    beat_count_next = beat_count_reg;
    if (accept) begin
      beat_count_next = beat_count_reg + 1'b1;
      if (bus.rr_en) begin
        rr_ptr_next = rr_ptr_reg + 1'b1;
      end
    end
  end

  // Pointer and counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg     <= '0;
      beat_count_reg <= '0;
    end else begin
      rr_ptr_reg     <= rr_ptr_next;
      beat_count_reg <= beat_count_next;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_flat;
  assign bus.out_data   = out_data_flat;
  assign bus.rr_ptr     = rr_ptr_reg;
  assign bus.beat_count = beat_count_reg;
endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux (4 channels, 8-bit data). A second instance
// with a 4-bit counter shares the same stimulus to exercise counter wrap.
`timescale 1ns/1ps
module tb_stream_demux;
  localparam int sb = 2;
  localparam int dw = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  stream_demux_if #(.switch_bits(sb), .data_width(dw), .count_width(16)) bus ();
  stream_demux_if #(.switch_bits(sb), .data_width(dw), .count_width(4))  bus_w ();

  stream_demux #(.switch_bits(sb), .data_width(dw), .count_width(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  stream_demux #(.switch_bits(sb), .data_width(dw), .count_width(4)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_w)
  );

  assign bus_w.in_valid  = bus.in_valid;
  assign bus_w.in_sel    = bus.in_sel;
  assign bus_w.in_data   = bus.in_data;
  assign bus_w.rr_en     = bus.rr_en;
  assign bus_w.out_ready = bus.out_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ch_data(input int c);
    return bus.out_data[c*dw +: dw];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One line per accepted beat.
  always @(posedge clk) begin
    if (rst_n && bus.in_valid && bus.in_ready)
      $display("beat ch=%0d data=%02h", bus.rr_en ? bus.rr_ptr : bus.in_sel, bus.in_data);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sel    = '0;
    bus.in_data   = '0;
    bus.rr_en     = 1'b0;
    bus.out_ready = '0;
    repeat (2) tick();

    // Reset state
    check("rst_valid", bus.out_valid, 4'b0000);
    check("rst_data", bus.out_data, 32'h0);
    check("rst_ptr", bus.rr_ptr, 0);
    check("rst_count", bus.beat_count, 0);
    check("rst_ready", bus.in_ready, 1);
    rst_n = 1'b1;

    // Single beat to ch2, 1-cycle latency then drain
    bus.out_ready = 4'b1111;
    bus.in_sel = 2'd2;
    bus.in_data = 8'hA5;
    bus.in_valid = 1'b1;
    #1 check("t1_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    check("t1_valid", bus.out_valid, 4'b0100);
    check("t1_data", ch_data(2), 8'hA5);
    check("t1_count", bus.beat_count, 1);
    tick();
    check("t1_drain", bus.out_valid, 4'b0000);
    check("t1_hold", ch_data(2), 8'hA5);

    // Round-robin, four back-to-back beats
    bus.rr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 8'h10 + 8'(i);
      bus.in_valid = 1'b1;
      #1;
      check("t2_ready", bus.in_ready, 1);
      check("t2_ptr", bus.rr_ptr, i);
      tick();
      check("t2_valid", bus.out_valid, 32'(1) << i);
      check("t2_data", ch_data(i), 8'h10 + 8'(i));
    end
    bus.in_valid = 1'b0;
    check("t2_wrap", bus.rr_ptr, 0);
    check("t2_count", bus.beat_count, 5);
    tick();

    // Backpressure on ch1, other channel unaffected, drain+fill
    bus.rr_en = 1'b0;
    bus.out_ready = 4'b1101;
    bus.in_sel = 2'd1;
    bus.in_data = 8'h20;
    bus.in_valid = 1'b1;
    #1 check("t3_ready_a", bus.in_ready, 1);
    tick();
    bus.in_data = 8'h21;
    #1 check("t3_stall", bus.in_ready, 0);
    tick();
    check("t3_valid_a", bus.out_valid, 4'b0010);
    check("t3_data_hold", ch_data(1), 8'h20);
    check("t3_count_a", bus.beat_count, 6);
    bus.in_sel = 2'd3;
    bus.in_data = 8'h30;
    #1 check("t3_ready_ch3", bus.in_ready, 1);
    tick();
    check("t3_valid_b", bus.out_valid, 4'b1010);
    check("t3_data_ch3", ch_data(3), 8'h30);
    bus.in_sel = 2'd1;
    bus.in_data = 8'h21;
    bus.out_ready = 4'b1111;
    #1 check("t3_ready_fill", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    check("t3_valid_c", bus.out_valid, 4'b0010);
    check("t3_data_new", ch_data(1), 8'h21);
    check("t3_count_b", bus.beat_count, 8);
    tick();
    check("t3_drain", bus.out_valid, 4'b0000);

    // Full throughput on ch0
    bus.in_sel = 2'd0;
    for (int i = 0; i < 8; i++) begin
      bus.in_data = 8'(i);
      bus.in_valid = 1'b1;
      #1 check("t4_ready", bus.in_ready, 1);
      tick();
      check("t4_valid", bus.out_valid, 4'b0001);
      check("t4_data", ch_data(0), i);
    end
    bus.in_valid = 1'b0;
    check("t4_count", bus.beat_count, 16);
    check("t4_ptr_hold", bus.rr_ptr, 0);
    tick();

    // Round-robin strict stall on ch0
    bus.rr_en = 1'b1;
    bus.out_ready = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 8'h40 + 8'(i);
      bus.in_valid = 1'b1;
      tick();
    end
    check("t5_ptr0", bus.rr_ptr, 0);
    check("t5_count_a", bus.beat_count, 20);
    bus.in_data = 8'h44;
    #1 check("t5_stall", bus.in_ready, 0);
    tick();
    check("t5_noskip", bus.rr_ptr, 0);
    check("t5_hold", ch_data(0), 8'h40);
    check("t5_count_b", bus.beat_count, 20);
    bus.out_ready = 4'b1111;
    #1 check("t5_ready", bus.in_ready, 1);
    tick();
    check("t5_ptr1", bus.rr_ptr, 1);
    check("t5_data", ch_data(0), 8'h44);
    check("t5_valid", bus.out_valid, 4'b0001);

    // Build up state, then asynchronous reset between edges
    bus.out_ready = 4'b0000;
    bus.in_data = 8'h60;
    tick();
    bus.rr_en = 1'b0;
    bus.in_sel = 2'd3;
    bus.in_data = 8'h63;
    tick();
    bus.in_valid = 1'b0;
    #1;
    check("t6_pre_valid", bus.out_valid, 4'b1011);
    check("t6_pre_ptr", bus.rr_ptr, 2);
    check("t6_pre_count", bus.beat_count, 23);
    check("t6_pre_data", ch_data(1), 8'h60);
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", bus.out_valid, 4'b0000);
    check("t6_data", bus.out_data, 32'h0);
    check("t6_ptr", bus.rr_ptr, 0);
    check("t6_count", bus.beat_count, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_no_stale", bus.out_valid, 4'b0000);

    // First beat after reset goes to ch0, then counter wrap on the 4-bit build
    bus.rr_en = 1'b1;
    bus.out_ready = 4'b1111;
    bus.in_data = 8'h70;
    bus.in_valid = 1'b1;
    tick();
    check("t6_first_valid", bus.out_valid, 4'b0001);
    check("t6_first_data", ch_data(0), 8'h70);
    check("t6_first_count", bus.beat_count, 1);
    check("t6_first_ptr", bus.rr_ptr, 1);
    check("t7_w_count_a", bus_w.beat_count, 1);
    for (int i = 1; i <= 16; i++) begin
      bus.in_data = 8'h70 + 8'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    check("t7_count", bus.beat_count, 17);
    check("t7_w_wrap", bus_w.beat_count, 1);
    check("t7_ptr", bus.rr_ptr, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
